// File: rtl/fsgn_pipe_pkg.sv
// Purpose : shared op encoding and result helper for the FP sign-injection unit.
// Latency : n/a (types and pure functions only).
// Backpr. : n/a.
// Contents: sgn_op_e op encoding, MAX_W bound, sign_idx() sign position,
//           sgn_result() reference of the sign-injection datapath.
package fpu_sgn_pkg;

    // Operation encoding as driven on in_op by the FPU issue logic.
    typedef enum logic [1:0] {
        SGNJ    = 2'b00,
        SGNJN   = 2'b01,
        SGNJX   = 2'b10,
        SGN_RSV = 2'b11
    } sgn_op_e;

    // Widest operand the helper handles; narrower operands are zero-extended.
    localparam int MAX_W = 64;

    // The sign lives in the MSB of an IEEE-754 operand of the given width.
    function automatic int sign_idx(input int width);
        return width - 1;
    endfunction

    // Reserved op codes are flagged so the issue logic can raise an exception.
    function automatic logic is_illegal(input sgn_op_e op);
        return (op == SGN_RSV);
    endfunction

    // Only bit sidx is ever rewritten; every other bit of a passes through
    // untouched, so NaN payloads, denormals and infinities stay bit-exact.
    function automatic logic [MAX_W-1:0] sgn_result(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input sgn_op_e          op,
        input int               sidx
    );
        logic [MAX_W-1:0] r;
        r = a;
        case (op)
            SGNJ:    r[sidx] = b[sidx];
            SGNJN:   r[sidx] = ~b[sidx];
            SGNJX:   r[sidx] = a[sidx] ^ b[sidx];
            default: r       = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fsgn_slice.sv
// Purpose : one elastic register slice (valid bit plus payload) of the pipe.
// Latency : 1 cycle from load to visible output.
// Backpr. : loads only when ld is high; otherwise valid and payload are held.
// Ports   : clk/rstn clock and sync active-low reset; ld load enable from the
//           advance chain; up_v/up_dat upstream beat; v/dat registered beat.
module fsgn_slice #(
    parameter int PW = 38
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          ld,
    input  logic          up_v,
    input  logic [PW-1:0] up_dat,
    output logic          v,
    output logic [PW-1:0] dat
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v   <= 1'b0;
            dat <= '0;
        end else if (ld) begin
            v <= up_v;
            // Bubbles do not overwrite the payload, so out_res only moves
            // when a real beat arrives.
            if (up_v) begin
                dat <= up_dat;
            end
        end
    end

endmodule

// File: rtl/fsgn_pipe.sv
// Purpose : pipelined fsgnj/fsgnjn/fsgnjx unit with a pass-through tag.
// Latency : STAGES cycles (1..4), full throughput when out_ready is high.
// Backpr. : valid/ready per slice; in_ready falls only when every slice holds
//           a beat that cannot advance (combinational from out_ready).
// Ports   : in_* input beat (rs1 in_a, rs2 in_b, op, tag) with in_valid /
//           in_ready; out_* result beat with out_valid / out_ready;
//           occupancy = number of valid slices.
module fsgn_pipe
    import fpu_sgn_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [2:0]       occupancy
);

    // Payload layout: {illegal, tag, result}.
    localparam int PW = WIDTH + TAG_W + 1;

    logic [MAX_W-1:0] a_ext;
    logic [MAX_W-1:0] b_ext;
    logic [MAX_W-1:0] r_ext;
    logic [WIDTH-1:0] head_res;
    logic             head_ill;
    logic             unused_bits;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] up_v;
    logic [PW-1:0]     up_dat [STAGES];
    logic [PW-1:0]     dat    [STAGES];

    // The whole computation sits in front of slice 0; later slices only delay.
    always_comb begin
        a_ext    = MAX_W'(in_a);
        b_ext    = MAX_W'(in_b);
        r_ext    = sgn_result(a_ext, b_ext, sgn_op_e'(in_op), sign_idx(WIDTH));
        head_res = r_ext[WIDTH-1:0];
        head_ill = is_illegal(sgn_op_e'(in_op));
    end

    // Upper helper bits exist only when WIDTH < MAX_W.
    assign unused_bits = ^r_ext;

    // Advance chain, walked from the output back to the input.
    // adv[k]: the beat in slice k may leave it this cycle.
    // ld[k] : slice k may take a new beat (it is empty or being emptied).
    always_comb begin
        adv = '0;
        ld  = '0;
        adv[STAGES-1] = out_ready;
        ld[STAGES-1]  = ~v[STAGES-1] | out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = ld[k+1];
            ld[k]  = ~v[k] | adv[k];
        end
    end

    // Slice inputs: slice 0 from the port, slice k from slice k-1.
    always_comb begin
        up_v[0]   = in_valid;
        up_dat[0] = {head_ill, in_tag, head_res};
        for (int k = 1; k < STAGES; k++) begin
            up_v[k]   = v[k-1];
            up_dat[k] = dat[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        fsgn_slice #(
            .PW (PW)
        ) u_slice (
            .clk    (clk),
            .rstn   (rstn),
            .ld     (ld[k]),
            .up_v   (up_v[k]),
            .up_dat (up_dat[k]),
            .v      (v[k]),
            .dat    (dat[k])
        );
    end

    assign in_ready    = ld[0];
    assign out_valid   = v[STAGES-1];
    assign out_res     = dat[STAGES-1][WIDTH-1:0];
    assign out_tag     = dat[STAGES-1][WIDTH +: TAG_W];
    assign out_illegal = dat[STAGES-1][PW-1];

    // STAGES is at most 4, so the count always fits in 3 bits.
    always_comb begin
        occupancy = 3'd0;
        for (int k = 0; k < STAGES; k++) begin
            occupancy = occupancy + 3'(v[k]);
        end
    end

endmodule
